// File: rtl/iter_mpy2_pkg.sv
// iter_mpy2_pkg: shared state type, step-counter sizing and 2 x B partial-product reference model
package iter_mpy2_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PP_MAXW = 64;
  function automatic int step_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic [PP_MAXW+1:0] pp2(input logic [1:0] s, input logic [PP_MAXW-1:0] b);
    return (s[0] ? {2'b0, b} : '0) + (s[1] ? {1'b0, b, 1'b0} : '0);
  endfunction
endpackage

// File: rtl/iter_mpy2_pp.sv
// iter_mpy2_pp: exact 2 x BW partial product as a ripple XOR/AND adder of b and b<<1
module iter_mpy2_pp #(
  parameter int BW = 16
) (
  input  logic [1:0]    s,
  input  logic [BW-1:0] b,
  output logic [BW+1:0] p
);
  logic [BW+1:0] x, y;
  logic c;
  always_comb begin
    x = s[0] ? {2'b0, b} : '0;
    y = s[1] ? {1'b0, b, 1'b0} : '0;
    c = 1'b0;
    p = '0;
    for (int i = 0; i < BW + 2; i++) begin
      p[i] = x[i] ^ y[i] ^ c;
      c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
  end
endmodule

// File: rtl/iter_mpy2.sv
// iter_mpy2: iterative AW x BW multiplier retiring 2 bits of A per clock; define ITER_MPY2_SIGNED_EN for two's-complement operands
module iter_mpy2
  import iter_mpy2_pkg::*;
#(
  parameter int AW = 16,
  parameter int BW = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stb,
  input  logic [AW-1:0]    i_a,
  input  logic [BW-1:0]    i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [AW+BW-1:0] o_p
);
  localparam int NSTEP = AW / 2;
  localparam int KW = step_w(NSTEP);
  localparam int PW = AW + BW;
  state_t st, st_n;
  logic [AW-1:0] sa, a_in;
  logic [BW-1:0] rb, b_in;
  logic [PW-1:0] acc, sum_n, res;
  logic [KW-1:0] k;
  logic [BW+1:0] pp;
  logic last, start;
  iter_mpy2_pp #(.BW(BW)) u_pp (.s(sa[1:0]), .b(rb), .p(pp));
  assign last = k == KW'(NSTEP - 1);
  assign start = st == IDLE && i_stb;
  assign sum_n = acc + (PW'(pp) << {k, 1'b0});
`ifdef ITER_MPY2_SIGNED_EN
  logic neg;
  assign a_in = i_a[AW-1] ? -i_a : i_a;
  assign b_in = i_b[BW-1] ? -i_b : i_b;
  assign res = neg ? -sum_n : sum_n;
  always_ff @(posedge i_clk)
    if (i_reset) neg <= 1'b0;
    else if (start) neg <= i_a[AW-1] ^ i_b[BW-1];
`else
  assign a_in = i_a;
  assign b_in = i_b;
  assign res = sum_n;
`endif
  always_comb begin
    st_n = st;
    st_n = (st == IDLE) ? (i_stb ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st <= IDLE;
      sa <= '0;
      rb <= '0;
      acc <= '0;
      k <= '0;
      o_p <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      st <= st_n;
      o_done <= 1'b0;
      if (start) begin
        sa <= a_in;
        rb <= b_in;
        acc <= '0;
        k <= '0;
        o_busy <= 1'b1;
      end else if (st == RUN) begin
        acc <= sum_n;
        sa <= sa >> 2;
        k <= k + 1'b1;
        if (last) begin
          o_p <= res;
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_iter_mpy2.sv
// tb_iter_mpy2: scoreboard bench for iter_mpy2 (AW=BW=16); expectations follow ITER_MPY2_SIGNED_EN when defined
module tb_iter_mpy2;
  logic clk = 1'b0, rst = 1'b1, stb = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] p;
  logic [31:0] q[$];
  int nvec = 0, nerr = 0;
  iter_mpy2 #(.AW(16), .BW(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_p(p)
  );
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] u, input logic [31:0] s);
`ifdef ITER_MPY2_SIGNED_EN
    return s;
`else
    return u;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
    logic signed [31:0] r;
    r = $signed(x) * $signed(y);
    return pick({16'b0, x} * {16'b0, y}, r);
  endfunction

  always @(negedge clk)
    if (!rst && done) begin
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk("product", p, q.pop_front());
    end

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [31:0] e);
    a = x;
    b = y;
    stb = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    q.push_back(e);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string n);
    int lat;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk(n, 32'(lat), 32'd8);
  endtask

  task automatic run(input logic [15:0] x, input logic [15:0] y, input logic [31:0] e, input string n);
    @(negedge clk);
    issue(x, y, e);
    wait_done(n);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_p", p, 32'd0);
    @(negedge clk) rst = 1'b0;
    run(16'd3, 16'd5, 32'h0000000F, "lat_3x5");
    chk("busy_cleared", 32'(busy), 32'd0);
    @(posedge clk);
    #1 chk("done_one_cycle", 32'(done), 32'd0);
    chk("p_holds", p, 32'h0000000F);
    run(16'hFFFF, 16'hFFFF, pick(32'hFFFE0001, 32'h00000001), "lat_ffff");
    run(16'h0000, 16'hABCD, 32'h00000000, "lat_zero");
    run(16'h8000, 16'h8000, 32'h40000000, "lat_8000");
    run(16'h0009, 16'h0009, 32'h00000051, "lat_9x9");
    // A=7 arrives while 2x2 is running and must be dropped
    @(negedge clk);
    issue(16'd2, 16'd2, 32'd4);
    @(posedge clk);
    @(posedge clk);
    #1 a = 16'd7;
    stb = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    chk("busy_ignore", 32'(busy), 32'd1);
    begin
      int lat;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        #1;
        if (done) begin
          lat = i;
          break;
        end
      end
      chk("lat_2x2", 32'(lat), 32'd5);
    end
    a = 16'hFFFD;
    b = 16'h0005;
    stb = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    q.push_back(pick(32'h0004FFF1, 32'hFFFFFFF1));
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done("lat_b2b");
    // reset aborts a 9x9 mid-flight; the monitor flags any stray o_done
    @(negedge clk);
    a = 16'd9;
    b = 16'd9;
    stb = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_p", p, 32'd0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      y = 16'($urandom);
      run(x, y, model(x, y), "lat_rand");
    end
    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
